// File: rtl/cmd_decode_pkg.sv
// cmd_decode_pkg: shared definitions for the DDR3 command decoder.
//   - command codes, {ras_n, cas_n, we_n}, active-low
//   - bit positions inside err_flags
//   - width of the per-bank and refresh down-counters
package cmd_decode_pkg;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_ZQ  = 3'b110;

  localparam int ERR_ACT_OPEN = 0;  // ACT to a bank that already has a row open
  localparam int ERR_CLOSED   = 1;  // RD/WR to a closed bank, or REF/MRS/ZQ with rows open
  localparam int ERR_RCD      = 2;  // RD/WR before tRCD has elapsed
  localparam int ERR_TIMING   = 3;  // ACT inside tRP, or any command inside tRFC
  localparam int ERR_SLOT     = 4;  // command dropped: second slot, tristate or CKE low
  localparam int ERR_W        = 5;

  localparam int TIMER_W = 8;

  function automatic logic is_rdwr(input logic [2:0] code);
    return (code == CMD_RD) || (code == CMD_WR);
  endfunction

endpackage

// File: rtl/cmd_decode_bank.sv
// cmd_decode_bank: state of one DDR3 bank as seen by the decoder.
//   clk_div, rst_n : clock, asynchronous active-low reset
//   act_i          : accepted ACT to this bank (opens it, starts tRCD)
//   rdwr_i         : accepted RD/WR to this bank
//   pre_i          : accepted PRE to this bank or PRE-all (closes it, starts tRP)
//   open_o         : a row is open
//   rcd_busy_o     : tRCD still running
//   rp_busy_o      : tRP still running
//   rdwr_closed_o  : rdwr_i while the bank is closed
//   rdwr_early_o   : rdwr_i while tRCD is still running
module cmd_decode_bank
  import cmd_decode_pkg::*;
#(
  parameter int T_RCD = 3,
  parameter int T_RP  = 3
) (
  input  logic clk_div,
  input  logic rst_n,
  input  logic act_i,
  input  logic rdwr_i,
  input  logic pre_i,
  output logic open_o,
  output logic rcd_busy_o,
  output logic rp_busy_o,
  output logic rdwr_closed_o,
  output logic rdwr_early_o
);

  localparam logic [TIMER_W-1:0] RCD_LOAD = TIMER_W'(T_RCD - 1);
  localparam logic [TIMER_W-1:0] RP_LOAD  = TIMER_W'(T_RP - 1);

  logic               open_q;
  logic [TIMER_W-1:0] rcd_q;
  logic [TIMER_W-1:0] rp_q;

  // A load replaces the decrement in the cycle it happens, so a command
  // exactly T cycles later sees the counter at zero.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= 1'b0;
      rcd_q  <= '0;
      rp_q   <= '0;
    end else begin
      if (act_i) begin
        open_q <= 1'b1;
        rcd_q  <= RCD_LOAD;
      end else if (rcd_q != '0) begin
        rcd_q <= rcd_q - 1'b1;
      end
      if (pre_i) begin
        open_q <= 1'b0;
        rp_q   <= RP_LOAD;
      end else if (rp_q != '0) begin
        rp_q <= rp_q - 1'b1;
      end
    end
  end

  assign open_o        = open_q;
  assign rcd_busy_o    = (rcd_q != '0);
  assign rp_busy_o     = (rp_q != '0);
  assign rdwr_closed_o = rdwr_i && !open_q;
  assign rdwr_early_o  = rdwr_i && (rcd_q != '0);

endmodule

// File: rtl/cmd_decode.sv
// cmd_decode: two-slot DDR3 command decoder and protocol checker.
//   clk_div, rst_n       : only clock, asynchronous active-low reset
//   in_a/in_ba/in_we/... : two command slots per cycle (slot 0 in the low half)
//   in_tri               : command bus tristated, any command is dropped
//   err_clr              : clears err_flags (a new error in the same cycle survives)
//   cmd_*                : decoded accepted command, cmd_valid is a one-cycle strobe
//   open_banks           : one bit per bank, row open
//   err_flags            : sticky protocol errors (see cmd_decode_pkg)
//   cmd_count            : saturating count of accepted commands
// Pipeline: inputs registered, decoded next cycle, outputs registered (N+2).
module cmd_decode
  import cmd_decode_pkg::*;
#(
  parameter int ADDRESS_NUMBER = 15,
  parameter int T_RCD          = 3,
  parameter int T_RP           = 3,
  parameter int T_RFC          = 44
) (
  input  logic                        clk_div,
  input  logic                        rst_n,
  input  logic [2*ADDRESS_NUMBER-1:0] in_a,
  input  logic [5:0]                  in_ba,
  input  logic [1:0]                  in_we,
  input  logic [1:0]                  in_ras,
  input  logic [1:0]                  in_cas,
  input  logic [1:0]                  in_cke,
  input  logic [1:0]                  in_odt,
  input  logic                        in_tri,
  input  logic                        err_clr,
  output logic                        cmd_valid,
  output logic [2:0]                  cmd_code,
  output logic                        cmd_slot,
  output logic [2:0]                  cmd_bank,
  output logic [ADDRESS_NUMBER-1:0]   cmd_addr,
  output logic [7:0]                  open_banks,
  output logic [ERR_W-1:0]            err_flags,
  output logic [15:0]                 cmd_count
);

  localparam int AN = ADDRESS_NUMBER;
  localparam logic [TIMER_W-1:0] RFC_LOAD = TIMER_W'(T_RFC - 1);

  // Stage 1: input registers, reset to an idle (NOP, tristated) bus.
  logic [2*AN-1:0] a_q;
  logic [5:0]      ba_q;
  logic [1:0]      we_q, ras_q, cas_q, cke_q, odt_q;
  logic            tri_q;

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      ba_q  <= '0;
      we_q  <= 2'b11;
      ras_q <= 2'b11;
      cas_q <= 2'b11;
      cke_q <= 2'b11;
      odt_q <= 2'b00;
      tri_q <= 1'b1;
    end else begin
      a_q   <= in_a;
      ba_q  <= in_ba;
      we_q  <= in_we;
      ras_q <= in_ras;
      cas_q <= in_cas;
      cke_q <= in_cke;
      odt_q <= in_odt;
      tri_q <= in_tri;
    end
  end

  // Stage 2: slot selection. The first non-NOP slot is the candidate; a
  // non-NOP in slot 1 behind a non-NOP in slot 0 is always dropped.
  logic [2:0]    code0, code1, sel_code, sel_bank;
  logic [AN-1:0] sel_addr;
  logic          nop0, nop1, sel_slot, any_cmd, accept;

  assign code0    = {ras_q[0], cas_q[0], we_q[0]};
  assign code1    = {ras_q[1], cas_q[1], we_q[1]};
  assign nop0     = (code0 == CMD_NOP);
  assign nop1     = (code1 == CMD_NOP);
  assign any_cmd  = !nop0 || !nop1;
  assign sel_slot = nop0;
  assign sel_code = sel_slot ? code1 : code0;
  assign sel_bank = sel_slot ? ba_q[5:3] : ba_q[2:0];
  assign sel_addr = sel_slot ? a_q[2*AN-1:AN] : a_q[AN-1:0];
  assign accept   = any_cmd && !tri_q && cke_q[sel_slot];

  // Per-bank state.
  logic [7:0] act_v, rdwr_v, pre_v;
  logic [7:0] open_v, rcd_busy_v, rp_busy_v, rdwr_closed_v, rdwr_early_v;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bank
      assign act_v[gi]  = accept && (sel_code == CMD_ACT) && (sel_bank == 3'(gi));
      assign rdwr_v[gi] = accept && is_rdwr(sel_code) && (sel_bank == 3'(gi));
      // a[10] on PRE selects precharge-all.
      assign pre_v[gi]  = accept && (sel_code == CMD_PRE) &&
                          (sel_addr[10] || (sel_bank == 3'(gi)));

      cmd_decode_bank #(
        .T_RCD(T_RCD),
        .T_RP (T_RP)
      ) u_bank (
        .clk_div      (clk_div),
        .rst_n        (rst_n),
        .act_i        (act_v[gi]),
        .rdwr_i       (rdwr_v[gi]),
        .pre_i        (pre_v[gi]),
        .open_o       (open_v[gi]),
        .rcd_busy_o   (rcd_busy_v[gi]),
        .rp_busy_o    (rp_busy_v[gi]),
        .rdwr_closed_o(rdwr_closed_v[gi]),
        .rdwr_early_o (rdwr_early_v[gi])
      );
    end
  endgenerate

  // Refresh timer.
  logic [TIMER_W-1:0] rfc_q;
  logic               global_cmd;

  assign global_cmd = accept && ((sel_code == CMD_REF) || (sel_code == CMD_MRS) ||
                                 (sel_code == CMD_ZQ));

  // Error detection for the command in stage 2.
  logic [ERR_W-1:0] err_set;

  always_comb begin
    err_set               = '0;
    err_set[ERR_ACT_OPEN] = |(act_v & open_v);
    err_set[ERR_CLOSED]   = (|rdwr_closed_v) || (global_cmd && (|open_v));
    err_set[ERR_RCD]      = |rdwr_early_v;
    err_set[ERR_TIMING]   = (|(act_v & rp_busy_v)) || (accept && (rfc_q != '0));
    err_set[ERR_SLOT]     = (!nop0 && !nop1) || (any_cmd && !accept);
  end

  // Output registers.
  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NOP;
      cmd_slot  <= 1'b0;
      cmd_bank  <= 3'd0;
      cmd_addr  <= '0;
      err_flags <= '0;
      cmd_count <= 16'd0;
      rfc_q     <= '0;
    end else begin
      cmd_valid <= accept;
      if (accept) begin
        cmd_code <= sel_code;
        cmd_slot <= sel_slot;
        cmd_bank <= sel_bank;
        cmd_addr <= sel_addr;
        if (cmd_count != 16'hFFFF) cmd_count <= cmd_count + 16'd1;
      end
      // A new error outranks a clear arriving in the same cycle.
      err_flags <= (err_clr ? '0 : err_flags) | err_set;
      if (accept && (sel_code == CMD_REF)) rfc_q <= RFC_LOAD;
      else if (rfc_q != '0)                rfc_q <= rfc_q - 1'b1;
    end
  end

  assign open_banks = open_v;

endmodule

// File: tb/tb_cmd_decode.sv
// Directed bench for cmd_decode: each command is driven for one cycle and its
// decoded result is checked two clock edges later.
module tb_cmd_decode;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;

  logic        clk_div = 1'b0;
  logic        rst_n   = 1'b1;
  logic [29:0] in_a;
  logic [5:0]  in_ba;
  logic [1:0]  in_we, in_ras, in_cas, in_cke, in_odt;
  logic        in_tri;
  logic        err_clr;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic        cmd_slot;
  logic [2:0]  cmd_bank;
  logic [14:0] cmd_addr;
  logic [7:0]  open_banks;
  logic [4:0]  err_flags;
  logic [15:0] cmd_count;

  int n_checks = 0;
  int n_err    = 0;

  cmd_decode #(
    .ADDRESS_NUMBER(15),
    .T_RCD         (3),
    .T_RP          (3),
    .T_RFC         (44)
  ) dut (
    .clk_div   (clk_div),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_ba     (in_ba),
    .in_we     (in_we),
    .in_ras    (in_ras),
    .in_cas    (in_cas),
    .in_cke    (in_cke),
    .in_odt    (in_odt),
    .in_tri    (in_tri),
    .err_clr   (err_clr),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_slot  (cmd_slot),
    .cmd_bank  (cmd_bank),
    .cmd_addr  (cmd_addr),
    .open_banks(open_banks),
    .err_flags (err_flags),
    .cmd_count (cmd_count)
  );

  always #5 clk_div = ~clk_div;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %-16s observed=0x%0h expected=0x%0h ok", tag, obs, exp);
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  task automatic set_nop();
    in_a   = '0;
    in_ba  = '0;
    in_we  = 2'b11;
    in_ras = 2'b11;
    in_cas = 2'b11;
    in_cke = 2'b11;
    in_odt = 2'b00;
    in_tri = 1'b0;
  endtask

  task automatic put(input int s, input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
    in_ras[s]       = c[2];
    in_cas[s]       = c[1];
    in_we[s]        = c[0];
    in_ba[s*3 +: 3] = b;
    in_a[s*15 +: 15] = a;
  endtask

  task automatic issue(input int s, input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
    set_nop();
    put(s, c, b, a);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    set_nop();
    err_clr = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(cmd_valid), 32'h0);
    chk("rst_code", 32'(cmd_code), 32'h7);
    chk("rst_open", 32'(open_banks), 32'h0);
    chk("rst_err", 32'(err_flags), 32'h0);
    chk("rst_count", 32'(cmd_count), 32'h0);
    rst_n = 1'b1;
    tick();

    // ACT bank 2 row 0x123, three NOPs, RD bank 2: legal.
    issue(0, C_ACT, 3'd2, 15'h123);
    tick();
    set_nop();
    tick();
    chk("act_valid", 32'(cmd_valid), 32'h1);
    chk("act_code", 32'(cmd_code), 32'h3);
    chk("act_bank", 32'(cmd_bank), 32'h2);
    chk("act_addr", 32'(cmd_addr), 32'h123);
    chk("act_open", 32'(open_banks), 32'h04);
    tick();
    chk("nop_valid", 32'(cmd_valid), 32'h0);
    tick();
    issue(0, C_RD, 3'd2, 15'h0);
    tick();
    set_nop();
    tick();
    chk("rd_valid", 32'(cmd_valid), 32'h1);
    chk("rd_code", 32'(cmd_code), 32'h5);
    chk("rd_err", 32'(err_flags), 32'h0);
    chk("rd_count", 32'(cmd_count), 32'h2);
    chk("rd_open", 32'(open_banks), 32'h04);

    // ACT bank 1 then RD bank 1 next cycle (tRCD), then RD to closed bank 5.
    issue(0, C_ACT, 3'd1, 15'h55);
    tick();
    issue(0, C_RD, 3'd1, 15'h0);
    tick();
    chk("act1_open", 32'(open_banks), 32'h06);
    chk("act1_err", 32'(err_flags), 32'h0);
    issue(0, C_RD, 3'd5, 15'h0);
    tick();
    chk("rcd_err", 32'(err_flags), 32'h04);
    set_nop();
    tick();
    chk("closed_err", 32'(err_flags), 32'h06);
    chk("closed_bank", 32'(cmd_bank), 32'h5);
    chk("closed_count", 32'(cmd_count), 32'h5);
    clear_errors();
    chk("clr_err", 32'(err_flags), 32'h0);

    // Open banks 0 and 3, PRE-all, ACT bank 0 the next cycle (tRP).
    issue(0, C_ACT, 3'd0, 15'h1);
    tick();
    issue(0, C_ACT, 3'd3, 15'h2);
    tick();
    set_nop();
    tick();
    chk("open4_open", 32'(open_banks), 32'h0F);
    chk("open4_err", 32'(err_flags), 32'h0);
    issue(0, C_PRE, 3'd0, 15'h0400);
    tick();
    issue(0, C_ACT, 3'd0, 15'h7);
    tick();
    set_nop();
    chk("preall_open", 32'(open_banks), 32'h00);
    chk("preall_code", 32'(cmd_code), 32'h2);
    tick();
    chk("rp_open", 32'(open_banks), 32'h01);
    chk("rp_err", 32'(err_flags), 32'h08);
    chk("rp_count", 32'(cmd_count), 32'h9);
    clear_errors();
    chk("clr2_err", 32'(err_flags), 32'h0);

    // ACT slot 0 and RD slot 1 in the same cycle.
    issue(0, C_ACT, 3'd4, 15'h10);
    put(1, C_RD, 3'd4, 15'h0);
    tick();
    set_nop();
    tick();
    chk("dual_valid", 32'(cmd_valid), 32'h1);
    chk("dual_slot", 32'(cmd_slot), 32'h0);
    chk("dual_bank", 32'(cmd_bank), 32'h4);
    chk("dual_err", 32'(err_flags), 32'h10);
    chk("dual_count", 32'(cmd_count), 32'hA);
    chk("dual_open", 32'(open_banks), 32'h11);
    tick();
    chk("dual_single", 32'(cmd_valid), 32'h0);
    clear_errors();

    // WR in slot 1 only.
    issue(1, C_WR, 3'd0, 15'h20);
    tick();
    set_nop();
    tick();
    chk("s1_slot", 32'(cmd_slot), 32'h1);
    chk("s1_code", 32'(cmd_code), 32'h4);
    chk("s1_addr", 32'(cmd_addr), 32'h20);
    chk("s1_err", 32'(err_flags), 32'h0);
    chk("s1_count", 32'(cmd_count), 32'hB);

    // RD with CKE low in its slot is dropped.
    issue(0, C_RD, 3'd0, 15'h0);
    in_cke = 2'b10;
    tick();
    set_nop();
    tick();
    chk("cke_valid", 32'(cmd_valid), 32'h0);
    chk("cke_err", 32'(err_flags), 32'h10);
    chk("cke_count", 32'(cmd_count), 32'hB);
    clear_errors();

    // PRE-all, REF with all banks closed, ACT ten cycles later (tRFC).
    issue(0, C_PRE, 3'd0, 15'h0400);
    tick();
    issue(0, C_REF, 3'd0, 15'h0);
    tick();
    set_nop();
    tick();
    tick();
    chk("ref_code", 32'(cmd_code), 32'h1);
    chk("ref_err", 32'(err_flags), 32'h0);
    chk("ref_count", 32'(cmd_count), 32'hD);
    repeat (8) tick();
    issue(0, C_ACT, 3'd6, 15'h66);
    tick();
    set_nop();
    tick();
    chk("rfc_err", 32'(err_flags), 32'h08);
    chk("rfc_open", 32'(open_banks), 32'h40);
    clear_errors();
    chk("clr3_err", 32'(err_flags), 32'h0);

    // Asynchronous reset mid-sequence with a bank open and a command in flight.
    issue(0, C_ACT, 3'd2, 15'h22);
    tick();
    set_nop();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(cmd_valid), 32'h0);
    chk("arst_code", 32'(cmd_code), 32'h7);
    chk("arst_bank", 32'(cmd_bank), 32'h0);
    chk("arst_addr", 32'(cmd_addr), 32'h0);
    chk("arst_open", 32'(open_banks), 32'h0);
    chk("arst_count", 32'(cmd_count), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst_noleak", 32'(cmd_valid), 32'h0);
    issue(0, C_ACT, 3'd5, 15'h5);
    tick();
    set_nop();
    tick();
    chk("post_open", 32'(open_banks), 32'h20);
    chk("post_err", 32'(err_flags), 32'h0);
    chk("post_count", 32'(cmd_count), 32'h1);

    // 70000 PRE-all commands: counter saturates.
    issue(0, C_PRE, 3'd0, 15'h0400);
    repeat (70000) tick();
    set_nop();
    tick();
    tick();
    chk("sat_count", 32'(cmd_count), 32'hFFFF);
    chk("sat_err", 32'(err_flags), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cmd_decode.md
# cmd_decode

Pin-level DDR3 command decoder and protocol checker for the clk_div-domain command/address interface: the receiving end of the 2-bit-per-signal command format (slot 0 = first clk half, slot 1 = second). Consumes the same in_a/in_ba/in_we/in_ras/in_cas/in_cke/in_odt/in_tri vectors the command/address driver serializes. Emits a decoded command stream, tracks per-bank open rows and timers, and raises sticky protocol-error flags. Used as loopback monitor in the PHY and as a synthesizable checker in simulation.

## Interface
- ADDRESS_NUMBER, 15, address bits per slot
- T_RCD, 3, min clk_div cycles ACT→RD/WR same bank
- T_RP, 3, min clk_div cycles PRE→ACT same bank
- T_RFC, 44, min clk_div cycles REF→any non-NOP
- clk_div  in  1  free-running half-frequency clock; only clock
- rst_n  in  1  asynchronous, active-low reset
- in_a  in  2*ADDRESS_NUMBER  slot 0 = [ADDRESS_NUMBER-1:0], slot 1 = upper half
- in_ba  in  6  slot 0 = [2:0], slot 1 = [5:3]
- in_we, in_ras, in_cas, in_cke, in_odt  in  2 each  bit 0 = slot 0, bit 1 = slot 1
- in_tri  in  1  bus tristated
- err_clr  in  1  clears err_flags
- cmd_valid  out  1  one-cycle strobe, decoded non-NOP command
- cmd_code  out  3  {ras,cas,we} of the command, active-low encoding
- cmd_slot  out  1  slot the command occupied
- cmd_bank  out  3  bank address
- cmd_addr  out  ADDRESS_NUMBER  address
- open_banks  out  8  bit per bank, 1 = row open
- err_flags  out  5  sticky protocol errors
- cmd_count  out  16  saturating count of accepted commands

## Operation
- Codes {ras,cas,we}: 111 NOP, 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 ZQ.
- Per cycle: slot 0 decoded first; first non-NOP slot accepted. Non-NOP in both slots: slot 0 accepted, slot 1 dropped, err[4].
- Any non-NOP while in_tri=1 or cke of that slot=0: not accepted (no cmd_valid), err[4].
- ACT: bank open, store row (addr), load rcd_cnt[bank]=T_RCD-1. ACT to open bank → err[0]; rp_cnt[bank]≠0 → err[3]. ACT still applied.
- RD/WR: bank closed → err[1]; rcd_cnt[bank]≠0 → err[2].
- PRE: a[10]=1 → all banks closed, all rp_cnt=T_RP-1; else target bank only. PRE to closed bank legal.
- REF: any bank open → err[1]; load rfc_cnt=T_RFC-1. Any non-NOP accepted while rfc_cnt≠0 → err[3].
- MRS, ZQ: any bank open → err[1].
- Counters decrement by 1 per cycle to 0, hold at 0. Reload beats decrement same cycle.
- Erroneous commands (other than err[4] drops) still decoded, counted, and update state.
- err_flags bits set-only; err_clr clears; set in same cycle as err_clr wins.
- cmd_count +1 per accepted command, saturates at 0xFFFF.

## Timing
- Inputs registered in stage 1; decode/check in stage 2; outputs registered. Command in cycle N → cmd_valid, err update, open_banks update at cycle N+2.
- Timers measured from the stage-2 cycle; back-to-back ACT→RD spaced exactly T_RCD cycles is legal, T_RCD-1 flags err[2].
- Reset (any time, mid-sequence): cmd_valid=0, cmd_code=3'b111, cmd_slot=0, cmd_bank=0, cmd_addr=0, open_banks=0, err_flags=0, cmd_count=0, all timers 0, input registers to NOP (we/ras/cas=2'b11, cke=2'b11, odt=0, in_tri=1). First command sampled the cycle after rst_n deasserts.

## Structure
- Shared package: command code constants (CMD_NOP … CMD_ZQ), err bit index constants, timer width.
- Sub-module cmd_decode_bank (one per bank, generate ×8): open flag, row register, rcd_cnt, rp_cnt; inputs act/rdwr/pre strobes; outputs open, rcd_busy, rp_busy.
- Top: input register stage, slot select, rfc counter, error/count logic.

## Test plan
- ACT bank 2 row 0x123, 3 NOPs, RD bank 2 → cmd_valid twice, open_banks=0x04, err_flags=0, cmd_count=2.
- ACT bank 1 then RD bank 1 next cycle → err[2]=1; RD to bank 5 closed → err[1]=1.
- PRE a[10]=1 with banks 0,3 open, ACT bank 0 next cycle → open_banks=0x01 after, err[3]=1.
- ACT in slot 0 and RD in slot 1 same cycle → single cmd_valid with cmd_slot=0, err[4]=1, cmd_count=1.
- REF with all closed, ACT after 10 cycles → err[3]=1; err_clr pulse → err_flags=0 next cycle.
- rst_n low mid-sequence with banks open → all outputs at reset values asynchronously; 70000 commands → cmd_count=0xFFFF.
